// File: rtl/jtag_bridge_pkg.sv
// Shared types and constants for the JTAG USER1 data-register to bus bridge.
package jtag_bridge_pkg;

    localparam int JTAG_ADDR_WIDTH = 32;
    localparam int JTAG_DATA_WIDTH = 32;
    localparam int JTAG_REQ_BITS   = 1 + JTAG_ADDR_WIDTH + JTAG_DATA_WIDTH;

    // Read data returned when a read request times out with no slave response.
    localparam logic [JTAG_DATA_WIDTH-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic                       we;
        logic [JTAG_ADDR_WIDTH-1:0] addr;
        logic [JTAG_DATA_WIDTH-1:0] data;
    } jtag_request_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } bridge_state_t;

endpackage

// File: rtl/jtag_input_sync.sv
// Multi-stage synchroniser for the BSCAN outputs, plus a one-clk strobe on each
// rising edge of the synchronised TCK.
module jtag_input_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tck,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] data_sync,
    output logic             tck_rise
);

    // TCK travels in bit 0 so every JTAG input sees exactly the same latency.
    logic [WIDTH:0] stage [STAGES];
    logic           tck_d;

    // NOTE: every flop here uses <= so the chain shifts one stage per clk; a
    // blocking assignment would collapse the stages into a single flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= '0;
            tck_d <= 1'b0;
        end else begin
            stage[0] <= {data, tck};
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
            tck_d <= stage[STAGES-1][0];
        end
    end

    assign data_sync = stage[STAGES-1][WIDTH:1];
    assign tck_rise  = stage[STAGES-1][0] & ~tck_d;

endmodule

// File: rtl/jtag_dr_bus_bridge.sv
// JTAG USER1 DR responder: shifts in {we, addr, data}, runs one bus transaction
// per Update-DR on clk, and returns {err|busy, last_addr, rdata} on Capture-DR.
module jtag_dr_bus_bridge
    import jtag_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  jtag_tck,
    input  logic                  jtag_tdi,
    input  logic                  jtag_sel,
    input  logic                  jtag_capture,
    input  logic                  jtag_shift,
    input  logic                  jtag_update,
    output logic                  jtag_tdo,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  busy,
    output logic                  err
);

    localparam int SR_W  = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [4:0] sync_q;
    logic       tck_rise;

    jtag_input_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (5)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .tck       (jtag_tck),
        .data      ({jtag_update, jtag_shift, jtag_capture, jtag_sel, jtag_tdi}),
        .data_sync (sync_q),
        .tck_rise  (tck_rise)
    );

    logic s_tdi, s_capture, s_shift, s_update, tap_act;
    assign s_tdi     = sync_q[0];
    assign s_capture = sync_q[2];
    assign s_shift   = sync_q[3];
    assign s_update  = sync_q[4];
    assign tap_act   = tck_rise & sync_q[1];

    logic [SR_W-1:0]       sr;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [CNT_W-1:0]      timeout_cnt;
    bridge_state_t         state;
    logic                  timeout_hit;

    assign busy        = (state == ST_REQ);
    assign bus_req     = busy;
    assign jtag_tdo    = sr[0];
    assign timeout_hit = (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sr          <= '0;
            rdata_q     <= '0;
            last_addr   <= '0;
            timeout_cnt <= '0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            err         <= 1'b0;
            state       <= ST_IDLE;
        end else begin
            if (tap_act && s_shift)
                sr <= {s_tdi, sr[SR_W-1:1]};
            else if (tap_act && s_capture)
                sr <= {err | busy, last_addr, rdata_q};

            case (state)
                ST_IDLE: begin
                    timeout_cnt <= '0;
                    if (tap_act && s_update) begin
                        bus_we    <= sr[SR_W-1];
                        bus_addr  <= sr[SR_W-2 -: ADDR_WIDTH];
                        bus_wdata <= sr[DATA_WIDTH-1:0];
                        last_addr <= sr[SR_W-2 -: ADDR_WIDTH];
                        err       <= 1'b0;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A second update while outstanding is dropped and flagged.
                    if (tap_act && s_update) err <= 1'b1;
                    if (bus_ack) begin
                        if (!bus_we) rdata_q <= bus_rdata;
                        state <= ST_IDLE;
                    end else if (timeout_hit) begin
                        err <= 1'b1;
                        if (!bus_we) rdata_q <= DATA_WIDTH'(TIMEOUT_RDATA);
                        state <= ST_IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_dr_bus_bridge.sv
// Self-checking bench: table-driven directed transactions, corner-case sequences
// and randomized traffic checked against a transaction-level model.
module tb_jtag_dr_bus_bridge;
    import jtag_bridge_pkg::*;

    localparam int TO   = 16;
    localparam int HALF = 4;

    logic        clk, reset;
    logic        jtag_tck, jtag_tdi, jtag_sel, jtag_capture, jtag_shift, jtag_update;
    logic        jtag_tdo, bus_req, bus_we, bus_ack, busy, err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    jtag_dr_bus_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .jtag_tck     (jtag_tck),
        .jtag_tdi     (jtag_tdi),
        .jtag_sel     (jtag_sel),
        .jtag_capture (jtag_capture),
        .jtag_shift   (jtag_shift),
        .jtag_update  (jtag_update),
        .jtag_tdo     (jtag_tdo),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tck_pulse(input logic tdi, input logic sel, input logic cap,
                             input logic sh, input logic upd);
        jtag_tdi = tdi; jtag_sel = sel; jtag_capture = cap;
        jtag_shift = sh; jtag_update = upd;
        tick(HALF);
        jtag_tck = 1'b1;
        tick(HALF);
        jtag_tck = 1'b0;
    endtask

    // tdo is sampled before each shift edge, as a JTAG host would see it.
    task automatic scan(input logic [64:0] din, input logic do_cap, input logic sel,
                        output logic [64:0] dout);
        if (do_cap) tck_pulse(1'b0, sel, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 65; i++) begin
            dout[i] = jtag_tdo;
            tck_pulse(din[i], sel, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic update_pulse(input logic sel);
        tck_pulse(1'b0, sel, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 200 && bus_req; k++) tick(1);
        check(name, bus_req, 1'b0);
        tick(1);
    endtask

    function automatic logic [64:0] rand65();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Bus slave: acks after ack_delay cycles of bus_req, or never if ack_en=0.
    logic        ack_en;
    int          ack_delay;
    logic [31:0] slave_rdata;
    int          age;

    initial begin
        bus_ack = 1'b0; bus_rdata = '0; age = 0;
        forever begin
            @(posedge clk); #1;
            if (bus_ack) begin
                bus_ack = 1'b0; age = 0;
            end else if (bus_req) begin
                age++;
                if (ack_en && age == ack_delay) begin
                    bus_ack = 1'b1; bus_rdata = slave_rdata;
                end
            end else begin
                age = 0;
            end
        end
    end

    // Monitor: counts requests, their length, and any change while held.
    int            req_count = 0, high_cnt = 0, last_high = 0, hold_viol = 0;
    jtag_request_t last_seen;
    logic          prev_req = 1'b0;

    initial begin
        forever begin
            @(posedge clk); #1;
            if (bus_req && !prev_req) begin
                req_count++;
                last_seen = {bus_we, bus_addr, bus_wdata};
                high_cnt  = 1;
            end else if (bus_req) begin
                high_cnt++;
                if ({bus_we, bus_addr, bus_wdata} !== last_seen) hold_viol++;
            end
            if (!bus_req && prev_req) last_high = high_cnt;
            prev_req = bus_req;
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        int          delay;      // 0: slave never acks
        logic [31:0] rdata;
        int          exp_high;
        logic [64:0] exp_scan;   // {err, last_addr, rdata_q} after this request
    } vec_t;

    vec_t vecs[6];

    // Transaction-level model of what the next capture must return.
    logic        m_err;
    logic [31:0] m_last, m_rdata;

    initial begin
        logic [64:0]   dout, prev_exp, pat;
        jtag_request_t req;
        logic          t0;
        int            rc;

        vecs[0] = '{1'b1, 32'h0000_1004, 32'hA5A5_5A5A, 3,  32'h0,         3,  {1'b0, 32'h0000_1004, 32'h0}};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         3,  32'h1234_5678, 3,  {1'b0, 32'h0000_0010, 32'h1234_5678}};
        vecs[2] = '{1'b0, 32'h0000_0020, 32'h0,         0,  32'h0,         TO, {1'b1, 32'h0000_0020, 32'hDEAD_BEEF}};
        vecs[3] = '{1'b1, 32'h0000_0030, 32'hCAFE_0001, 1,  32'h0,         1,  {1'b0, 32'h0000_0030, 32'hDEAD_BEEF}};
        vecs[4] = '{1'b0, 32'h0000_0040, 32'h0,         16, 32'h0BAD_F00D, 16, {1'b0, 32'h0000_0040, 32'h0BAD_F00D}};
        vecs[5] = '{1'b1, 32'h0000_0044, 32'h7777_8888, 0,  32'h0,         TO, {1'b1, 32'h0000_0044, 32'h0BAD_F00D}};

        reset = 1'b1; ack_en = 1'b0; ack_delay = 0; slave_rdata = '0;
        jtag_tck = 0; jtag_tdi = 0; jtag_sel = 0; jtag_capture = 0; jtag_shift = 0; jtag_update = 0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("reset_tdo", jtag_tdo, 1'b0);
        check("reset_req", bus_req, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_bus", {bus_we, bus_addr, bus_wdata}, '0);

        prev_exp = '0;
        for (int i = 0; i < 6; i++) begin
            req = {vecs[i].we, vecs[i].addr, vecs[i].data};
            ack_en = (vecs[i].delay != 0); ack_delay = vecs[i].delay; slave_rdata = vecs[i].rdata;
            scan(req, 1'b1, 1'b1, dout);
            check($sformatf("vec%0d_scan", i), dout, prev_exp);
            rc = req_count;
            update_pulse(1'b1);
            wait_idle($sformatf("vec%0d_done", i));
            check($sformatf("vec%0d_nreq", i), req_count - rc, 1);
            check($sformatf("vec%0d_req", i), last_seen, req);
            check($sformatf("vec%0d_len", i), last_high, vecs[i].exp_high);
            check($sformatf("vec%0d_err", i), err, vecs[i].exp_scan[64]);
            check($sformatf("vec%0d_busy", i), busy, 1'b0);
            prev_exp = vecs[i].exp_scan;
        end

        pat = rand65();
        scan(pat, 1'b1, 1'b1, dout);
        check("table_last_scan", dout, prev_exp);

        // Deselected scan and update must leave sr, tdo and the bus untouched.
        rc = req_count;
        t0 = jtag_tdo;
        scan(rand65(), 1'b1, 1'b0, dout);
        update_pulse(1'b0);
        tick(4);
        check("desel_nreq", req_count - rc, 0);
        check("desel_tdo_stream", dout, {65{t0}});
        check("desel_tdo", jtag_tdo, t0);
        req = {1'b0, 32'h0000_0100, 32'h1111_2222};
        scan(req, 1'b0, 1'b1, dout);
        check("desel_sr_kept", dout, pat);

        // Overrun: second update while the first is still outstanding.
        ack_en = 1'b1; ack_delay = 12; slave_rdata = 32'h600D_CAFE;
        rc = req_count;
        update_pulse(1'b1);
        check("ovr_req_high", bus_req, 1'b1);
        update_pulse(1'b1);
        wait_idle("ovr_done");
        check("ovr_nreq", req_count - rc, 1);
        check("ovr_addr_seen", last_seen.addr, 32'h0000_0100);
        check("ovr_bus_addr", bus_addr, 32'h0000_0100);
        check("ovr_err", err, 1'b1);
        m_err = 1'b1; m_last = 32'h0000_0100; m_rdata = 32'h600D_CAFE;

        for (int i = 0; i < 24; i++) begin
            logic timeout;
            req = rand65();
            timeout = ($urandom_range(0, 9) >= 8);
            ack_en = !timeout; ack_delay = $urandom_range(1, TO); slave_rdata = $urandom;
            scan(req, 1'b1, 1'b1, dout);
            check($sformatf("rnd%0d_scan", i), dout, {m_err, m_last, m_rdata});
            update_pulse(1'b1);
            wait_idle($sformatf("rnd%0d_done", i));
            check($sformatf("rnd%0d_req", i), last_seen, req);
            check($sformatf("rnd%0d_len", i), last_high, timeout ? TO : ack_delay);
            m_last = req.addr;
            m_err  = timeout;
            if (!req.we) m_rdata = timeout ? TIMEOUT_RDATA : slave_rdata;
            check($sformatf("rnd%0d_err", i), err, m_err);
        end

        // Reset while a read is outstanding.
        ack_en = 1'b0;
        req = {1'b0, 32'h0000_0ABC, 32'h0};
        scan(req, 1'b1, 1'b1, dout);
        check("rst_pre_scan", dout, {m_err, m_last, m_rdata});
        update_pulse(1'b1);
        check("rst_req_before", bus_req, 1'b1);
        reset = 1'b1;
        tick(1);
        check("rst_req", bus_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_tdo", jtag_tdo, 1'b0);
        reset = 1'b0;
        tick(2);
        scan('0, 1'b1, 1'b1, dout);
        check("rst_scan", dout, '0);
        check("hold_stable", hold_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_dr_bus_bridge.md
Name: jtag_dr_bus_bridge

Overview:
- JTAG USER data-register responder. Deserialises 65-bit requests {we, addr[31:0], data[31:0]} shifted in via the BSCAN USER1 chain, issues them as single bus transactions on the system clock, and returns read data on the next DR scan.
- Sits between the BSCAN primitive outputs and the system bus master port. It is the target end of the host-side JTAG load_data / load_data_read transactions.

Parameters:
- ADDR_WIDTH, 32, bus/request address width
- DATA_WIDTH, 32, bus/request data width
- SYNC_STAGES, 2, synchroniser depth for all JTAG inputs
- TIMEOUT_CYCLES, 1024, clk cycles without bus_ack before abort

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- jtag_tck  in  1  TCK from BSCAN; asynchronous to clk
- jtag_tdi  in  1  TDI from BSCAN
- jtag_sel  in  1  USER1 instruction selected
- jtag_capture  in  1  TAP in Capture-DR
- jtag_shift  in  1  TAP in Shift-DR
- jtag_update  in  1  TAP in Update-DR
- jtag_tdo  out  1  serial response bit (sr[0])
- bus_req  out  1  transaction request
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_WIDTH  address
- bus_wdata  out  DATA_WIDTH  write data
- bus_ack  in  1  one-cycle completion strobe
- bus_rdata  in  DATA_WIDTH  read data, valid with bus_ack
- busy  out  1  transaction outstanding
- err  out  1  sticky error (timeout or overrun)

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high. All six JTAG inputs pass through SYNC_STAGES flops.
- TCK edge detect: tck_rise = sync_tck & ~sync_tck_d. All TAP actions happen only in tck_rise cycles with sync_sel=1. The other synced inputs are sampled from the same stage.
- TCK period requirement: jtag_tck period ≥ 8 clk periods.
- Shift register: SR_W = 1+ADDR_WIDTH+DATA_WIDTH (65).
  - Shift: sr <= {tdi, sr[SR_W-1:1]}. Data is LSB first: data[0..31], then addr[0..31], then we.
  - Capture: sr <= {err|busy, last_addr, rdata_q}.
  - jtag_tdo = sr[0], registered. Shift takes priority over capture if both are seen.
- Update with busy=0:
  - Latch bus_we=sr[64], bus_addr=sr[63:32], bus_wdata=sr[31:0].
  - Set last_addr, clear err.
  - Assert bus_req the next clk.
- Update with busy=1: request discarded, err<=1, bus outputs unchanged.
- FSM states: IDLE -> REQ (on accepted update) -> IDLE.
  - REQ: bus_req=1, busy=1. Outputs are held stable until bus_ack.
  - bus_ack: bus_req drops the following cycle. Reads set rdata_q<=bus_rdata; writes leave rdata_q unchanged.
  - Timeout: counter runs in REQ. At TIMEOUT_CYCLES without ack, return to IDLE, err<=1, and rdata_q<=32'hDEAD_BEEF if the request was a read.
  - bus_ack in the same cycle as timeout expiry: ack wins.
  - bus_ack in IDLE is ignored.
- Read pipeline: a Capture-DR returns the result of the previous Update-DR. A capture while still busy returns stale rdata_q with bit 64 = 1.
- Reset values: sr=0, jtag_tdo=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, rdata_q=0, last_addr=0, busy=0, err=0, FSM=IDLE, timeout counter=0.
- Reset mid-transaction: bus_req is 0 at the next edge. No completion is recorded.

Decomposition:
- Package jtag_bridge_pkg:
  - Jtag_request_t packed struct {we, addr, data}
  - JTAG_ADDR_WIDTH / JTAG_DATA_WIDTH = 32
  - JTAG_REQ_BITS = 65
  - TIMEOUT_RDATA = 32'hDEAD_BEEF
  - FSM state enum
- Sub-module jtag_input_sync: SYNC_STAGES multi-bit synchroniser plus tck_rise strobe generation.

Test Plan:
1. Write: shift 65 bits {we=1, addr=0x0000_1004, data=0xA5A5_5A5A}, then update; slave acks after 3 clk -> exactly one bus_req, with we=1, addr=0x1004, wdata=0xA5A5_5A5A; bus_req low the clk after ack; busy=0; err=0.
2. Read: update {we=0, addr=0x10}; slave acks with rdata 0x1234_5678; next capture+65 shifts -> tdo stream LSB first gives data=0x1234_5678, addr=0x10, bit64=0.
3. Timeout: TIMEOUT_CYCLES=16, read with no ack -> bus_req drops after 16 clk; err=1; next scan gives data=0xDEAD_BEEF, bit64=1; next accepted update clears err.
4. Overrun: hold bus_ack low, issue second update -> no second bus_req; bus_addr keeps first value; err=1.
5. Deselect: full scan with jtag_sel=0 -> no bus_req; sr and tdo unchanged.
6. Reset mid-transaction: reset asserted while bus_req=1 -> next clk bus_req=0, busy=0, err=0, jtag_tdo=0; a later read scan returns data=0.
